multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter INSTRET_W, default 32, giving the retired-instruction counter width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port Opcode, input, 7, Inst[6:0] from the instruction register.
REQ-005 The block SHALL have port Funct3, input, 3, Inst[14:12].
REQ-006 The block SHALL have port Zero, input, 1, ALU zero flag.
REQ-007 The block SHALL have port MemReady, input, 1, memory completion strobe (used only under REQ-026).
REQ-008 The block SHALL have single-bit outputs PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, Branch, ClrLsb and Illegal.
REQ-009 The block SHALL have outputs ResultSrc, ALUSrcA and ALUSrcB, each 2 bits; ALUOp, 4 bits; State, 4 bits; InstRet, INSTRET_W bits.

Function
REQ-010 Encodings SHALL be as follows.
- AdrSrc: 0=PC, 1=Result.
- ALUSrcA: 00=PC, 01=OldPC, 10=RD1, 11=zero.
- ALUSrcB: 00=RD2 reg, 01=Imm, 10=4.
- ResultSrc: 00=ALUOut, 01=Data, 10=ALU_Result.
- ALUOp: 0000=add, 0001=sub, 0010=R-funct, 0011=I-funct.
REQ-011 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALR2, LUI and TRAP; the current encoding SHALL be driven on State.
REQ-012 Any control output not listed for a state SHALL be 0.
REQ-013 FETCH SHALL assert IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10 and PCWrite=1, then go to DECODE.
REQ-014 DECODE SHALL assert ALUSrcA=01, ALUSrcB=01 and ALUOp=add, then dispatch on Opcode.
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECR.
- 0010011 -> EXECI.
- 1100011 -> BRANCH.
- 1101111 -> JAL.
- 1100111 -> JALR.
- 0110111 -> LUI.
- Any other value -> TRAP.
REQ-015 MEMADR SHALL assert ALUSrcA=10, ALUSrcB=01 and add, then go to MEMREAD if Opcode[5]=0, else MEMWRITE.
REQ-016 MEMREAD SHALL assert AdrSrc=1 and ResultSrc=00, then go to MEMWB.
REQ-017 MEMWB SHALL assert ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-018 MEMWRITE SHALL assert AdrSrc=1, ResultSrc=00 and MemWrite=1, then go to FETCH.
REQ-019 EXECR SHALL assert ALUSrcA=10, ALUSrcB=00 and ALUOp=0010, then go to ALUWB; EXECI SHALL be identical except ALUSrcB=01 and ALUOp=0011.
REQ-020 LUI SHALL assert ALUSrcA=11, ALUSrcB=01 and add, then go to ALUWB.
REQ-021 ALUWB SHALL assert ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-022 BRANCH SHALL assert ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1 and PCWrite=(Zero XOR Funct3[0]), then go to FETCH.
REQ-023 JAL SHALL assert ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00 and PCWrite=1, then go to ALUWB.
REQ-024 JALR SHALL assert ALUSrcA=10, ALUSrcB=01 and add, then go to JALR2; JALR2 SHALL assert ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 and ClrLsb=1, then go to ALUWB.
REQ-025 TRAP SHALL drive all controls 0 and Illegal=1, and SHALL remain in TRAP until reset.
REQ-026 InstRet SHALL increment by 1 on each transition into FETCH, SHALL wrap from all-ones to 0, and SHALL not count FETCH-to-FETCH waits.

Reset
REQ-027 Asserting reset SHALL asynchronously force State=FETCH, InstRet=0 and Illegal=0, including mid-instruction and while in TRAP.
REQ-028 While reset is high, PCWrite, IRWrite, MemWrite and RegWrite SHALL be 0.
REQ-029 The first FETCH after reset deasserts SHALL occur on the first rising clk edge.

Configuration
REQ-030 With MULTICYCLE_WAIT_EN defined, FETCH, MEMREAD and MEMWRITE SHALL hold their state and outputs until MemReady=1.
REQ-031 With MULTICYCLE_WAIT_EN defined, IRWrite and PCWrite in FETCH SHALL be gated by MemReady.
REQ-032 With MULTICYCLE_WAIT_EN defined, MemWrite SHALL stay asserted through the wait.
REQ-033 Without MULTICYCLE_WAIT_EN, MemReady SHALL be ignored and every state SHALL last one cycle.

Structure
REQ-034 Package multicycle_pkg SHALL hold the state encoding, opcode constants, ALUOp codes and mux-select codes.
REQ-035 Combinational state-to-control decoding SHALL live in sub-module multicycle_ctrl_dec; next-state logic and InstRet SHALL remain in multicycle_ctrl.

Verification
REQ-036 Bench SHALL apply Opcode=0110011 after reset -> State FETCH,DECODE,EXECR,ALUWB,FETCH; RegWrite=1 only in ALUWB; InstRet=1.
REQ-037 Bench SHALL apply Opcode=0000011 -> 5-cycle sequence ending MEMWB with ResultSrc=01; Opcode=0100011 -> MemWrite=1 exactly one cycle (no WAIT_EN).
REQ-038 Bench SHALL apply Opcode=1100011 with Funct3=001, first Zero=0 then Zero=1 -> PCWrite=1 in BRANCH on the first pass and 0 on the second.
REQ-039 Bench SHALL apply Opcode=1100111 -> ClrLsb=1 only in JALR2, followed by ALUWB with RegWrite=1.
REQ-040 Bench SHALL apply Opcode=1111111 -> TRAP with Illegal=1 held 10 cycles; reset pulse -> FETCH, Illegal=0, InstRet=0.
REQ-041 Bench SHALL, with WAIT_EN and MemReady low 3 cycles in MEMWRITE, see MemWrite=1 for 4 cycles, and SHALL see InstRet preset to all-ones wrap to 0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: states, opcodes,
// ALUOp codes, mux selects and the packed control bundle.
package multicycle_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    JALR2    = 4'd12,
    LUI      = 4'd13,
    TRAP     = 4'd14
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALUOP_ADD = 4'b0000;
  localparam logic [3:0] ALUOP_SUB = 4'b0001;
  localparam logic [3:0] ALUOP_RFN = 4'b0010;
  localparam logic [3:0] ALUOP_IFN = 4'b0011;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       clr_lsb;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// State-to-control decoder; pure combinational. mem_ready_i gates the fetch
// write enables so a stalled fetch neither latches IR nor advances PC.
module multicycle_ctrl_dec
  import multicycle_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  input  logic               zero_i,
  input  logic               funct3_lsb_i,
  input  logic               mem_ready_i,
  output logic [CTRL_W-1:0]  ctrl_o
);

  state_e st;
  ctrl_t  c;

  assign st     = state_e'(state_i);
  assign ctrl_o = c;

  always_comb begin
    c = '0;
    case (st)
      FETCH: begin
        c.ir_write   = mem_ready_i;
        c.pc_write   = mem_ready_i;
        c.adr_src    = ADR_PC;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALU;
      end
      DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      MEMADR, JALR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      MEMREAD: begin
        c.adr_src    = ADR_RESULT;
        c.result_src = RES_ALUOUT;
      end
      MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        c.adr_src    = ADR_RESULT;
        c.result_src = RES_ALUOUT;
        c.mem_write  = 1'b1;
      end
      EXECR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_RD2;
        c.alu_op    = ALUOP_RFN;
      end
      EXECI: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_IFN;
      end
      LUI: begin
        c.alu_src_a = SRCA_ZERO;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      // BNE-style branches invert the sense of Zero via funct3[0]
      BRANCH: begin
        c.alu_src_a  = SRCA_RD1;
        c.alu_src_b  = SRCB_RD2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
        c.pc_write   = zero_i ^ funct3_lsb_i;
      end
      JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALUOUT;
        c.pc_write   = 1'b1;
      end
      JALR2: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALUOUT;
        c.pc_write   = 1'b1;
        c.clr_lsb    = 1'b1;
      end
      TRAP: c.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V main controller: state sequencing and retired-instruction
// counter. Define MULTICYCLE_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on MemReady.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           Opcode,
  input  logic [2:0]           Funct3,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 Branch,
  output logic                 ClrLsb,
  output logic                 Illegal,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [3:0]           ALUOp,
  output logic [3:0]           State,
  output logic [INSTRET_W-1:0] InstRet
);

  state_e               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 mem_ready;
  ctrl_t                ctrl;
  logic                 unused_funct3;

  assign unused_funct3 = ^Funct3[2:1];

`ifdef MULTICYCLE_WAIT_EN
  assign mem_ready = MemReady;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = MemReady;
  assign mem_ready        = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_LUI:            state_d = LUI;
          default:           state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = Opcode[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      MEMWB, ALUWB, BRANCH:           state_d = FETCH;
      EXECR, EXECI, LUI, JAL, JALR2:  state_d = ALUWB;
      JALR:     state_d = JALR2;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  // Count only genuine arrivals in FETCH, not fetch stalls
  always_comb begin
    instret_d = instret_q;
    if (state_d == FETCH && state_q != FETCH) instret_d = instret_q + INSTRET_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  multicycle_ctrl_dec u_dec (
    .state_i      (state_q),
    .zero_i       (Zero),
    .funct3_lsb_i (Funct3[0]),
    .mem_ready_i  (mem_ready),
    .ctrl_o       (ctrl)
  );

  // Write enables are held off for the whole reset pulse
  assign PCWrite   = ctrl.pc_write  & ~reset;
  assign IRWrite   = ctrl.ir_write  & ~reset;
  assign MemWrite  = ctrl.mem_write & ~reset;
  assign RegWrite  = ctrl.reg_write & ~reset;
  assign AdrSrc    = ctrl.adr_src;
  assign Branch    = ctrl.branch;
  assign ClrLsb    = ctrl.clr_lsb;
  assign Illegal   = ctrl.illegal;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign State     = state_q;
  assign InstRet   = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction state/control
// sequences from a behavioural model, randomized instruction mix and waits.
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  localparam int unsigned IW = 4;
`ifdef MULTICYCLE_WAIT_EN
  localparam bit WAIT = 1'b1;
`else
  localparam bit WAIT = 1'b0;
`endif

  localparam int B_PCW = 17, B_MW = 14, B_RW = 13, B_CLR = 11, B_ILL = 10;
  localparam logic [6:0] LEGAL [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                       7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

  logic          clk, reset, Zero, MemReady;
  logic [6:0]    Opcode;
  logic [2:0]    Funct3;
  logic          PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, Branch, ClrLsb, Illegal;
  logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0]    ALUOp, State;
  logic [IW-1:0] InstRet;

  int          total, bad;
  int unsigned exp_ret;
  state_e      obs_st[$];
  logic [17:0] obs_ctrl[$];

  multicycle_ctrl #(.INSTRET_W(IW)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct3(Funct3), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .Branch(Branch), .ClrLsb(ClrLsb),
    .Illegal(Illegal), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .State(State), .InstRet(InstRet)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] obs_vec();
    return {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, Branch, ClrLsb, Illegal,
            ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
  endfunction

  // Control values each state must present, straight from the control table
  function automatic logic [17:0] exp_ctrl(input state_e s, input logic f3_0,
                                           input logic z, input logic rdy);
    logic pcw, adr, irw, mw, rw, br, clr, ill, g;
    logic [1:0] res, sa, sb;
    logic [3:0] op;
    {pcw, adr, irw, mw, rw, br, clr, ill} = 8'd0;
    res = 2'b00; sa = 2'b00; sb = 2'b00; op = 4'b0000;
    g = WAIT ? rdy : 1'b1;
    case (s)
      FETCH:    begin irw = g; pcw = g; sb = 2'b10; res = 2'b10; end
      DECODE:   begin sa = 2'b01; sb = 2'b01; end
      MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      MEMREAD:  adr = 1'b1;
      MEMWB:    begin res = 2'b01; rw = 1'b1; end
      MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      EXECR:    begin sa = 2'b10; op = 4'b0010; end
      EXECI:    begin sa = 2'b10; sb = 2'b01; op = 4'b0011; end
      LUI:      begin sa = 2'b11; sb = 2'b01; end
      ALUWB:    rw = 1'b1;
      BRANCH:   begin sa = 2'b10; op = 4'b0001; br = 1'b1; pcw = z ^ f3_0; end
      JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      JALR:     begin sa = 2'b10; sb = 2'b01; end
      JALR2:    begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; clr = 1'b1; end
      TRAP:     ill = 1'b1;
      default:  ;
    endcase
    return {pcw, adr, irw, mw, rw, br, clr, ill, res, sa, sb, op};
  endfunction

  // Drive one instruction from FETCH onward, checking every cycle
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input int minw, input int maxw, input int extra, input string tag);
    state_e      base[$];
    state_e      sts[$];
    logic        rdys[$];
    logic [17:0] want, got;
    int          w;
    base.push_back(FETCH);
    base.push_back(DECODE);
    case (op)
      7'b0000011: begin base.push_back(MEMADR); base.push_back(MEMREAD); base.push_back(MEMWB); end
      7'b0100011: begin base.push_back(MEMADR); base.push_back(MEMWRITE); end
      7'b0110011: begin base.push_back(EXECR); base.push_back(ALUWB); end
      7'b0010011: begin base.push_back(EXECI); base.push_back(ALUWB); end
      7'b1100011: base.push_back(BRANCH);
      7'b1101111: begin base.push_back(JAL); base.push_back(ALUWB); end
      7'b1100111: begin base.push_back(JALR); base.push_back(JALR2); base.push_back(ALUWB); end
      7'b0110111: begin base.push_back(LUI); base.push_back(ALUWB); end
      default: begin
        base.push_back(TRAP);
        for (int k = 0; k < extra; k++) base.push_back(TRAP);
      end
    endcase
    foreach (base[k]) begin
      if (WAIT && (base[k] == FETCH || base[k] == MEMREAD || base[k] == MEMWRITE)) begin
        w = int'($urandom_range(maxw, minw));
        for (int j = 0; j < w; j++) begin sts.push_back(base[k]); rdys.push_back(1'b0); end
        sts.push_back(base[k]); rdys.push_back(1'b1);
      end else begin
        sts.push_back(base[k]); rdys.push_back(1'($urandom));
      end
    end
    obs_st.delete();
    obs_ctrl.delete();
    for (int i = 0; i < sts.size(); i++) begin
      @(negedge clk);
      Opcode = op; Funct3 = f3; Zero = z; MemReady = rdys[i];
      #1;
      want = exp_ctrl(sts[i], f3[0], z, rdys[i]);
      got  = obs_vec();
      obs_st.push_back(state_e'(State));
      obs_ctrl.push_back(got);
      total++;
      if (State !== sts[i] || got !== want || InstRet !== IW'(exp_ret)) begin
        bad++;
        $display("FAIL %s step%0d: state=%0d ctrl=%h instret=%0d, want state=%0d ctrl=%h instret=%0d",
                 tag, i, State, got, InstRet, sts[i], want, exp_ret);
      end
    end
    if (sts[sts.size()-1] != TRAP) exp_ret = (exp_ret + 1) % (1 << IW);
  endtask

  task automatic test_reset();
    reset = 1'b1; Opcode = 7'd0; Funct3 = 3'd0; Zero = 1'b0; MemReady = 1'b1;
    exp_ret = 0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (State !== FETCH || InstRet !== '0 || Illegal !== 1'b0 ||
        {PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0) begin
      bad++;
      $display("FAIL reset: state=%0d instret=%0d ill=%b we=%b, want state=0 instret=0 ill=0 we=0000",
               State, InstRet, Illegal, {PCWrite, IRWrite, MemWrite, RegWrite});
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_rtype();
    int rw_cnt;
    logic rw_ok;
    rw_cnt = 0; rw_ok = 1'b1;
    run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, 0, "rtype");
    foreach (obs_ctrl[k]) if (obs_ctrl[k][B_RW]) begin
      rw_cnt++;
      if (obs_st[k] != ALUWB) rw_ok = 1'b0;
    end
    total++;
    if (rw_cnt != 1 || !rw_ok) begin
      bad++;
      $display("FAIL rtype_regwrite: cycles=%0d only_aluwb=%b, want 1 and 1", rw_cnt, rw_ok);
    end
    #5;
    total++;
    if (InstRet !== IW'(1) || State !== FETCH) begin
      bad++;
      $display("FAIL rtype_instret: instret=%0d state=%0d, want 1 and 0", InstRet, State);
    end
  endtask

  task automatic test_load_store();
    int mw_cnt;
    mw_cnt = 0;
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 0, 0, "load");
    total++;
    if (obs_st.size() != 5 || obs_st[obs_st.size()-1] != MEMWB ||
        obs_ctrl[obs_ctrl.size()-1][9:8] !== 2'b01) begin
      bad++;
      $display("FAIL load_seq: len=%0d last=%0d res=%b, want 5 MEMWB 01",
               obs_st.size(), obs_st[obs_st.size()-1], obs_ctrl[obs_ctrl.size()-1][9:8]);
    end
    run_instr(7'b0100011, 3'b010, 1'b1, 0, 0, 0, "store");
    foreach (obs_ctrl[k]) if (obs_ctrl[k][B_MW]) mw_cnt++;
    total++;
    if (mw_cnt != 1) begin
      bad++;
      $display("FAIL store_memwrite: cycles=%0d, want 1", mw_cnt);
    end
  endtask

  task automatic test_branch();
    logic pcw;
    for (int p = 0; p < 2; p++) begin
      pcw = 1'bx;
      run_instr(7'b1100011, 3'b001, 1'(p), 0, 1, 0, "branch");
      foreach (obs_st[k]) if (obs_st[k] == BRANCH) pcw = obs_ctrl[k][B_PCW];
      total++;
      if (pcw !== (p == 0)) begin
        bad++;
        $display("FAIL branch_bne zero=%0d: pcwrite=%b, want %b", p, pcw, (p == 0));
      end
    end
  endtask

  task automatic test_jalr();
    int clr_cnt, at;
    clr_cnt = 0; at = -1;
    run_instr(7'b1100111, 3'b000, 1'b0, 0, 0, 0, "jalr");
    foreach (obs_ctrl[k]) if (obs_ctrl[k][B_CLR]) begin clr_cnt++; at = k; end
    total++;
    if (clr_cnt != 1 || at < 0 || at + 1 >= obs_st.size() || obs_st[at] != JALR2 ||
        obs_st[at+1] != ALUWB || !obs_ctrl[at+1][B_RW]) begin
      bad++;
      $display("FAIL jalr_clrlsb: cycles=%0d at=%0d, want 1 cycle in JALR2 then ALUWB+RegWrite",
               clr_cnt, at);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      run_instr(LEGAL[$urandom_range(7, 0)], 3'($urandom), 1'($urandom), 0, 2, 0, "random");
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 16 && exp_ret != 15; n++)
      run_instr(7'b0010011, 3'($urandom), 1'b0, 0, 0, 0, "wrap_fill");
    #5;
    total++;
    if (InstRet !== 4'hF) begin
      bad++;
      $display("FAIL wrap_full: instret=%0d, want 15", InstRet);
    end
    run_instr(7'b0110111, 3'b000, 1'b0, 0, 0, 0, "wrap_step");
    #5;
    total++;
    if (InstRet !== 4'h0) begin
      bad++;
      $display("FAIL wrap_zero: instret=%0d, want 0", InstRet);
    end
  endtask

  task automatic test_memwait();
    int mw_cnt, want;
    mw_cnt = 0;
`ifdef MULTICYCLE_WAIT_EN
    want = 4;
`else
    want = 1;
`endif
    run_instr(7'b0100011, 3'b010, 1'b0, 3, 3, 0, "memwait");
    foreach (obs_ctrl[k]) if (obs_ctrl[k][B_MW]) mw_cnt++;
    total++;
    if (mw_cnt != want) begin
      bad++;
      $display("FAIL memwait_memwrite: cycles=%0d, want %0d", mw_cnt, want);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    Opcode = 7'b0000011; MemReady = 1'b1;
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;
    #1;
    exp_ret = 0;
    total++;
    if (State !== FETCH || InstRet !== '0 || {PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0) begin
      bad++;
      $display("FAIL mid_reset: state=%0d instret=%0d we=%b, want 0 0 0000",
               State, InstRet, {PCWrite, IRWrite, MemWrite, RegWrite});
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_trap();
    int ill_cnt;
    ill_cnt = 0;
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 1, 10, "trap");
    foreach (obs_ctrl[k]) if (obs_ctrl[k][B_ILL]) ill_cnt++;
    total++;
    if (ill_cnt != 11) begin
      bad++;
      $display("FAIL trap_hold: illegal cycles=%0d, want 11", ill_cnt);
    end
    #2 reset = 1'b1;
    #1;
    exp_ret = 0;
    total++;
    if (State !== FETCH || Illegal !== 1'b0 || InstRet !== '0) begin
      bad++;
      $display("FAIL trap_reset: state=%0d ill=%b instret=%0d, want 0 0 0", State, Illegal, InstRet);
    end
    @(posedge clk); #1 reset = 1'b0;
    run_instr(7'b0110011, 3'b000, 1'b0, 0, 1, 0, "after_trap");
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_rtype();
    test_load_store();
    test_branch();
    test_jalr();
    test_random();
    test_wrap();
    test_memwait();
    test_mid_reset();
    test_trap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
